lcd_read_cycle: RTL and testbench

Read-side companion to the LCD write-cycle block. On a one-cycle-sampled request it drives an HD44780-style read cycle: RS and RW setup, an E pulse, and capture of the LCD data bus. It returns the byte (busy flag + address counter, or DDRAM/CGRAM data) with a completion strobe. It sits beside the writer under the LCD controller; the top level muxes E/RS/RW using `active`.

---
 rtl/lcd_read_cycle_pkg.sv | 18 +
 rtl/lcd_read_cycle.sv | 89 ++++++++
 tb/tb_lcd_read_cycle.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lcd_read_cycle_pkg.sv
// lcd_read_cycle_pkg: state encodings and LCD bus constants shared by the LCD reader and writer
package lcd_read_cycle_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EHI   = 3'd2,
        CAPT  = 3'd3,
        ELO   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic RS_CMD   = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/lcd_read_cycle.sv
// lcd_read_cycle: HD44780-style read cycle (RS/RW setup, E pulse, bus capture) with completion strobe
module lcd_read_cycle
    import lcd_read_cycle_pkg::*;
#(
    parameter bit BUS4 = 1'b0
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       rd_enable,
    input  logic       reg_sel,
    input  logic [7:0] db_in,
    output logic       rd_finish,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic       E_out,
    output logic       RW_out,
    output logic       RS_out,
    output logic       db_input_en,
    output logic       active
);

    state_t state, state_n;
    logic   nib, rs_q, rs_n, accept, last, bus_phase;

    assign accept    = (state == IDLE) && rd_enable;
    assign last      = !BUS4 || nib;
    assign rs_n      = accept ? reg_sel : rs_q;
    assign bus_phase = state_n inside {SETUP, EHI, CAPT, ELO};
    assign active    = state != IDLE;

    // state register
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state logic; a 4-bit read loops back to EHI once for the low nibble
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rd_enable ? SETUP : IDLE;
            SETUP:   state_n = EHI;
            EHI:     state_n = CAPT;
            CAPT:    state_n = ELO;
            ELO:     state_n = last ? DONE : EHI;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // nibble flag: cleared at accept, set when the first nibble's E pulse ends
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset)                        nib <= 1'b0;
        else if (accept)                  nib <= 1'b0;
        else if (state == ELO && BUS4 && !nib) nib <= 1'b1;
    end

    // register select latched at accept so later reg_sel changes are ignored
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset)       rs_q <= RS_CMD;
        else if (accept) rs_q <= reg_sel;
    end

    // registered Moore outputs decoded from the next state, plus capture on leaving CAPT
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            rd_finish   <= 1'b0;
            rd_data     <= 8'h00;
            busy_flag   <= 1'b0;
            E_out       <= 1'b0;
            RW_out      <= RW_WRITE;
            RS_out      <= RS_CMD;
            db_input_en <= 1'b0;
        end else begin
            E_out       <= state_n == EHI || state_n == CAPT;
            RW_out      <= bus_phase ? RW_READ : RW_WRITE;
            RS_out      <= state_n != IDLE ? rs_n : RS_CMD;
            db_input_en <= bus_phase;
            rd_finish   <= state_n == DONE;
            if (state == CAPT) begin
                if (!BUS4)     rd_data      <= db_in;
                else if (!nib) rd_data[7:4] <= db_in[7:4];
                else           rd_data[3:0] <= db_in[7:4];
                if (last) busy_flag <= (rs_q == RS_CMD) && (BUS4 ? rd_data[7] : db_in[7]);
            end
        end
    end

endmodule

// File: tb/tb_lcd_read_cycle.sv
// tb_lcd_read_cycle: directed vector and sequence checks for 8-bit and 4-bit read cycles
module tb_lcd_read_cycle;

    typedef struct packed {
        logic       en;
        logic       rs;
        logic [7:0] db;
        logic [5:0] flg;
        logic [7:0] data;
        logic       busy;
    } vec_t;

    logic       clk_1ms = 1'b0;
    logic       reset   = 1'b1;
    logic       en0 = 1'b0, en1 = 1'b0, reg_sel = 1'b0;
    logic [7:0] db_in = 8'h00;

    logic       fin0, busy0, e0, rw0, rs0, den0, act0;
    logic [7:0] data0;
    logic       fin1, busy1, e1, rw1, rs1, den1, act1;
    logic [7:0] data1;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t v[19];

    always #5 clk_1ms = ~clk_1ms;

    lcd_read_cycle #(.BUS4(1'b0)) dut8 (
        .clk_1ms(clk_1ms), .reset(reset), .rd_enable(en0), .reg_sel(reg_sel), .db_in(db_in),
        .rd_finish(fin0), .rd_data(data0), .busy_flag(busy0), .E_out(e0), .RW_out(rw0),
        .RS_out(rs0), .db_input_en(den0), .active(act0)
    );

    lcd_read_cycle #(.BUS4(1'b1)) dut4 (
        .clk_1ms(clk_1ms), .reset(reset), .rd_enable(en1), .reg_sel(reg_sel), .db_in(db_in),
        .rd_finish(fin1), .rd_data(data1), .busy_flag(busy1), .E_out(e1), .RW_out(rw1),
        .RS_out(rs1), .db_input_en(den1), .active(act1)
    );

    function automatic logic [14:0] obs8();
        return {e0, rw0, rs0, den0, fin0, act0, data0, busy0};
    endfunction

    function automatic logic [14:0] obs4();
        return {e1, rw1, rs1, den1, fin1, act1, data1, busy1};
    endfunction

    task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_1ms);
        #1;
    endtask

    // flags are {E, RW, RS, db_input_en, rd_finish, active}
    logic [5:0] f4[9];
    logic [7:0] d4[9];

    initial begin
        v[0]  = '{1'b1, 1'b0, 8'hA5, 6'b010101, 8'h00, 1'b0};
        v[1]  = '{1'b0, 1'b0, 8'hA5, 6'b110101, 8'h00, 1'b0};
        v[2]  = '{1'b0, 1'b0, 8'hA5, 6'b110101, 8'h00, 1'b0};
        v[3]  = '{1'b0, 1'b0, 8'hA5, 6'b010101, 8'hA5, 1'b1};
        v[4]  = '{1'b0, 1'b0, 8'h00, 6'b000011, 8'hA5, 1'b1};
        v[5]  = '{1'b0, 1'b0, 8'h00, 6'b000000, 8'hA5, 1'b1};
        v[6]  = '{1'b1, 1'b1, 8'h8C, 6'b011101, 8'hA5, 1'b1};
        v[7]  = '{1'b0, 1'b0, 8'h8C, 6'b111101, 8'hA5, 1'b1};
        v[8]  = '{1'b0, 1'b1, 8'h8C, 6'b111101, 8'hA5, 1'b1};
        v[9]  = '{1'b0, 1'b0, 8'h8C, 6'b011101, 8'h8C, 1'b0};
        v[10] = '{1'b0, 1'b0, 8'h00, 6'b001011, 8'h8C, 1'b0};
        v[11] = '{1'b0, 1'b0, 8'h00, 6'b000000, 8'h8C, 1'b0};
        v[12] = '{1'b1, 1'b0, 8'h5A, 6'b010101, 8'h8C, 1'b0};
        v[13] = '{1'b1, 1'b0, 8'h5A, 6'b110101, 8'h8C, 1'b0};
        v[14] = '{1'b0, 1'b0, 8'h5A, 6'b110101, 8'h8C, 1'b0};
        v[15] = '{1'b0, 1'b0, 8'h5A, 6'b010101, 8'h5A, 1'b0};
        v[16] = '{1'b0, 1'b0, 8'h5A, 6'b000011, 8'h5A, 1'b0};
        v[17] = '{1'b0, 1'b0, 8'h5A, 6'b000000, 8'h5A, 1'b0};
        v[18] = '{1'b0, 1'b0, 8'h5A, 6'b000000, 8'h5A, 1'b0};

        f4 = '{6'b010101, 6'b110101, 6'b110101, 6'b010101, 6'b110101,
               6'b110101, 6'b010101, 6'b000011, 6'b000000};
        d4 = '{8'h00, 8'h00, 8'h00, 8'h30, 8'h30, 8'h30, 8'h3C, 8'h3C, 8'h3C};

        #12;
        chk("reset8", obs8(), 15'd0);
        chk("reset4", obs4(), 15'd0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 19; i++) begin
            en0 = v[i].en; reg_sel = v[i].rs; db_in = v[i].db;
            cyc();
            chk($sformatf("vec%0d", i), obs8(), {v[i].flg, v[i].data, v[i].busy});
        end

        // 4-bit read: high nibble 3 captured first, then C; busy comes from the high nibble
        reg_sel = 1'b0;
        for (int k = 0; k < 9; k++) begin
            en1   = (k == 0);
            db_in = (k < 4) ? 8'h3F : 8'hC7;
            cyc();
            chk($sformatf("bus4_c%0d", k), obs4(), {f4[k], d4[k], 1'b0});
        end

        // back-to-back reads with reg_sel toggling every cycle; latched RS stays 1
        en0 = 1'b1; db_in = 8'hE1;
        for (int k = 0; k < 18; k++) begin
            reg_sel = (k % 2 == 0);
            cyc();
            chk($sformatf("b2b_c%0d", k), {13'd0, fin0, rs0}, {13'd0, k % 6 == 4, k % 6 != 5});
        end
        en0 = 1'b0;
        cyc();
        chk("b2b_data", {7'd0, data0}, {7'd0, 8'hE1});

        // reset asserted during CAPT clears everything including the old data
        en0 = 1'b1; reg_sel = 1'b0; db_in = 8'hFF;
        cyc();
        en0 = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_capt", obs8(), {6'b110101, 8'hE1, 1'b0});
        #3 reset = 1'b1;
        #1;
        chk("rst_capt", obs8(), 15'd0);
        reset = 1'b0;
        en0 = 1'b1; reg_sel = 1'b1; db_in = 8'h69;
        cyc();
        chk("rst_accept", obs8(), {6'b011101, 8'h00, 1'b0});
        en0 = 1'b0;
        for (int k = 1; k < 5; k++) cyc();
        chk("rst_reread", obs8(), {6'b001011, 8'h69, 1'b0});

        // reset during the second nibble's CAPT discards the partial high nibble
        en1 = 1'b1; reg_sel = 1'b0; db_in = 8'h9F;
        cyc();
        en1 = 1'b0;
        for (int k = 1; k < 6; k++) cyc();
        chk("pre_rst4", obs4(), {6'b110101, 8'h90, 1'b0});
        #3 reset = 1'b1;
        #1;
        chk("rst4", obs4(), 15'd0);
        reset = 1'b0;
        cyc();
        chk("rst4_idle", obs4(), 15'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
